clock_divider: RTL and testbench

CLOCK_DIVIDER -- requirements
Module: clock_divider

---
 rtl/clock_divider_pkg.sv | 11 +
 rtl/clock_divider_load_hs.sv | 25 ++
 rtl/clock_divider.sv | 93 +++++++++
 tb/tb_clock_divider.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared definitions for the clock divider: state encoding and default width.
package clock_divider_pkg;

    localparam int CD_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cd_state_t;

endpackage

// File: rtl/clock_divider_load_hs.sv
// Four-phase load handshake: accept pulses on the first cycle of a request,
// load_ack follows load_req one cycle later and drops once the request drops.
module load_hs (
    input  logic clock,
    input  logic reset_,
    input  logic load_req,
    output logic accept,
    output logic load_ack
);

    logic r_ack;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= load_req;
        end
    end

    // A held request is accepted only once because r_ack masks it after the first edge.
    assign accept   = load_req & ~r_ack;
    assign load_ack = r_ack;

endmodule

// File: rtl/clock_divider.sv
// Programmable clock divider: tick every D enabled cycles, clk_div toggles on
// each tick; new divisors are loaded through a four-phase handshake.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load_req,
    output logic             load_ack,
    output logic             tick,
    output logic             clk_div,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    cd_state_t        r_state;
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] r_pend_q;
    logic             r_pend_v;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tick;
    logic             r_clk_div;

    logic             w_accept;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next_div;

    load_hs u_load_hs (
        .clock    (clock),
        .reset_   (reset_),
        .load_req (load_req),
        .accept   (w_accept),
        .load_ack (load_ack)
    );

    assign w_wrap = (r_cnt == (r_div_q - ONE));

    // At a wrap a same-cycle accept beats the pending value, which beats the current one.
    assign w_next_div = w_accept ? div_in : (r_pend_v ? r_pend_q : r_div_q);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state   <= ST_IDLE;
            r_div_q   <= '0;
            r_pend_q  <= '0;
            r_pend_v  <= 1'b0;
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_div <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    if (w_accept) begin
                        r_div_q <= div_in;
                        r_state <= (div_in != '0) ? ST_RUN : ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (en && w_wrap) begin
                        r_cnt     <= '0;
                        r_tick    <= 1'b1;
                        r_clk_div <= ~r_clk_div;
                        r_div_q   <= w_next_div;
                        r_pend_v  <= 1'b0;
                        r_state   <= (w_next_div != '0) ? ST_RUN : ST_IDLE;
                    end else begin
                        r_tick <= 1'b0;
                        if (en) begin
                            r_cnt <= r_cnt + ONE;
                        end
                        if (w_accept) begin
                            r_pend_q <= div_in;
                            r_pend_v <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tick    = r_tick;
    assign clk_div = r_clk_div;
    assign count   = r_cnt;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: directed scenarios plus random traffic, checked
// cycle by cycle against a divisor-level reference model through a scoreboard.
module tb_clock_divider;

    localparam int W  = 8;
    localparam int EW = W + 3;

    logic         clock = 1'b0;
    logic         reset_ = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         load_req = 1'b0;
    logic         load_ack;
    logic         tick;
    logic         clk_div;
    logic [W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_on = 1'b0;

    logic [EW-1:0] exp_q[$];

    // Reference model state, expressed in divisor/period terms.
    int m_div, m_pend, m_cnt;
    bit m_pend_v, m_tick, m_clk, m_ack;

    clock_divider #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .en       (en),
        .div_in   (div_in),
        .load_req (load_req),
        .load_ack (load_ack),
        .tick     (tick),
        .clk_div  (clk_div),
        .count    (count)
    );

    always #5 clock = ~clock;

    function automatic logic [EW-1:0] pack_exp();
        logic [W-1:0] c;
        c = W'(m_cnt);
        return {m_ack, m_clk, m_tick, c};
    endfunction

    task automatic model_reset();
        m_div = 0; m_pend = 0; m_pend_v = 0; m_cnt = 0;
        m_tick = 0; m_clk = 0; m_ack = 0;
    endtask

    task automatic model_step(input bit e, input bit r, input int d);
        bit acc;
        int nd;
        acc   = r && !m_ack;
        m_ack = r;
        if (m_div == 0) begin
            m_cnt  = 0;
            m_tick = 0;
            if (acc) m_div = d;
        end else if (e) begin
            m_tick = ((m_cnt + 1) == m_div);
            m_cnt  = (m_cnt + 1) % m_div;
            if (m_tick) begin
                m_clk = !m_clk;
                nd = acc ? d : (m_pend_v ? m_pend : m_div);
                m_pend_v = 0;
                m_div = nd;
            end else if (acc) begin
                m_pend = d; m_pend_v = 1;
            end
        end else begin
            m_tick = 0;
            if (acc) begin
                m_pend = d; m_pend_v = 1;
            end
        end
    endtask

    // One clock cycle of stimulus; the expected response for the coming edge is queued.
    task automatic drive(input bit e, input bit r, input logic [W-1:0] d, input bit rst);
        logic [EW-1:0] act;
        @(negedge clock);
        en = e; load_req = r; div_in = d;
        if (rst) begin
            #2 reset_ = 1'b0;
            #1;
            act = {load_ack, clk_div, tick, count};
            n_checks++;
            if (act !== '0) begin
                n_errors++;
                $display("FAIL async_reset: got ack=%0b clk_div=%0b tick=%0b count=%0d, expected all 0",
                         act[W+2], act[W+1], act[W], act[W-1:0]);
            end
            model_reset();
        end else begin
            reset_ = 1'b1;
            model_step(e, r, int'(d));
        end
        exp_q.push_back(pack_exp());
        mon_on = 1'b1;
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) drive(e, 1'b0, W'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic load(input logic [W-1:0] d, input int hold);
        for (int i = 0; i < hold; i++) drive(1'b1, 1'b1, (i == 0) ? d : W'($urandom_range(0, 255)), 1'b0);
        drive(1'b1, 1'b0, W'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic run_until_cnt(input int c);
        for (int k = 0; k < 64 && m_cnt != c; k++) drive(1'b1, 1'b0, '0, 1'b0);
    endtask

    // Monitor: every rising edge the DUT presents a new output word.
    initial begin
        logic [EW-1:0] exp_v, act_v;
        forever begin
            @(posedge clock);
            #1;
            if (mon_on) begin
                act_v = {load_ack, clk_div, tick, count};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_empty at %0t: got %h with nothing expected", $time, act_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act_v !== exp_v) begin
                        n_errors++;
                        $display("FAIL cycle_out at %0t: got ack=%0b clk_div=%0b tick=%0b count=%0d, expected ack=%0b clk_div=%0b tick=%0b count=%0d",
                                 $time, act_v[W+2], act_v[W+1], act_v[W], act_v[W-1:0],
                                 exp_v[W+2], exp_v[W+1], exp_v[W], exp_v[W-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        bit rq;
        logic [W-1:0] dv;
        model_reset();

        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);

        // D=4 from IDLE: tick every 4th cycle, clk_div period 8.
        load(8'd4, 2);
        run(20, 1'b1);

        // Mid-period reload to D=2 applied at the next wrap.
        run_until_cnt(1);
        load(8'd2, 2);
        run(12, 1'b1);

        // D=3 with an en=0 freeze at cnt=1.
        load(8'd3, 1);
        for (int k = 0; k < 64 && !(m_div == 3 && m_cnt == 1); k++) drive(1'b1, 1'b0, '0, 1'b0);
        run(5, 1'b0);
        run(6, 1'b1);

        // D=5, then D=0 returns to IDLE at the next wrap.
        load(8'd5, 1);
        run(8, 1'b1);
        load(8'd0, 1);
        run(15, 1'b1);

        // Request held 6 cycles in IDLE: only the first value is taken.
        load(8'd3, 6);
        run(10, 1'b1);

        // D=1: tick and toggle every enabled cycle.
        load(8'd1, 1);
        run(6, 1'b1);

        // Reset mid-count with a pending divisor: back to IDLE, no ticks.
        load(8'd6, 1);
        run(3, 1'b1);
        load(8'd2, 1);
        drive(1'b1, 1'b0, '0, 1'b1);
        run(8, 1'b1);

        rq = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!rq && $urandom_range(0, 5) == 0) rq = 1'b1;
            else if (rq && $urandom_range(0, 2) == 0) rq = 1'b0;
            dv = W'($urandom_range(0, 7));
            drive($urandom_range(0, 9) != 0, rq, dv, $urandom_range(0, 299) == 0);
        end

        @(posedge clock);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
